// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default frame geometry, receiver state codes and the stereo sample payload.
package i2s_pkg;

    localparam int unsigned I2S_DATA_BITS = 24;
    localparam int unsigned I2S_SLOT_BITS = 32;

    localparam logic [1:0] SYNC_WAIT = 2'd0;
    localparam logic [1:0] LEFT      = 2'd1;
    localparam logic [1:0] RIGHT     = 2'd2;

    typedef struct packed {
        logic signed [I2S_DATA_BITS-1:0] left;
        logic signed [I2S_DATA_BITS-1:0] right;
    } sample_pair_t;

    // Bit counter width able to hold 0..slot_bits inclusive (saturation value).
    function automatic int unsigned cnt_width(input int unsigned slot_bits);
        return $clog2(slot_bits + 1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with a third stage for edge detection.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    // s1/s2 are the ASYNC_REG false-path pair; s3 only feeds edge detection.
    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q      = s2;
    assign rise_c = s2 & ~s3;
    assign fall_c = ~s2 & s3;

endmodule

// File: rtl/i2s_rx.sv
// I2S capture: oversamples SCLK/LRCLK/DOUT, deserializes each stereo frame and writes
// one {left, right} pair per frame into an external FIFO.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_BITS = I2S_DATA_BITS,
    parameter int unsigned SLOT_BITS = I2S_SLOT_BITS
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     ENABLE,
    input  logic                     CLEAR,
    input  logic                     SCLK,
    input  logic                     LRCLK,
    input  logic                     DOUT,
    input  logic                     FIFO_FULL,
    output logic                     FIFO_WRITE,
    output logic [2*DATA_BITS-1:0]   AUDIO,
    output logic                     OVERRUN,
    output logic                     FRAME_ERR
);

    localparam int unsigned CNT_W  = cnt_width(SLOT_BITS);
    localparam int unsigned PAIR_W = 2 * DATA_BITS;

    logic sclk_rise;
    logic sclk_s_unused;
    logic sclk_fall_unused;
    logic lr_s;
    logic lr_rise_unused;
    logic lr_fall_unused;
    logic dout_s;
    logic dout_rise_unused;
    logic dout_fall_unused;

    sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .d      (SCLK),
        .q      (sclk_s_unused),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall_unused)
    );

    // LRCLK resets high to agree with lr_prev, so no phantom boundary follows reset.
    sync_edge #(.RST_VAL(1'b1)) u_sync_lr (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .d      (LRCLK),
        .q      (lr_s),
        .rise_c (lr_rise_unused),
        .fall_c (lr_fall_unused)
    );

    sync_edge #(.RST_VAL(1'b0)) u_sync_dout (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .d      (DOUT),
        .q      (dout_s),
        .rise_c (dout_rise_unused),
        .fall_c (dout_fall_unused)
    );

    logic [1:0]           state_q,     state_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic                 lr_prev_q,   lr_prev_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] left_q,      left_d;
    logic [PAIR_W-1:0]    audio_q,     audio_d;
    logic                 write_q,     write_d;
    logic                 overrun_q,   overrun_d;
    logic                 frame_err_q, frame_err_d;

    logic [DATA_BITS-1:0] shift_in_c;
    logic                 take_bit_c;
    logic                 word_done_c;

    assign shift_in_c  = {shift_q[DATA_BITS-2:0], dout_s};
    assign take_bit_c  = (cnt_q < CNT_W'(DATA_BITS));
    assign word_done_c = (cnt_q == CNT_W'(DATA_BITS - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= SYNC_WAIT;
            cnt_q       <= '0;
            lr_prev_q   <= 1'b1;
            shift_q     <= '0;
            left_q      <= '0;
            audio_q     <= '0;
            write_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lr_prev_q   <= lr_prev_d;
            shift_q     <= shift_d;
            left_q      <= left_d;
            audio_q     <= audio_d;
            write_q     <= write_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Slot tracking, deserialization, pair emission and sticky error flags.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lr_prev_d   = lr_prev_q;
        shift_d     = shift_q;
        left_d      = left_q;
        audio_d     = audio_q;
        write_d     = 1'b0;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;

        // lr_prev follows LRCLK even while disabled so re-enable sees only real boundaries.
        if (sclk_rise) begin
            lr_prev_d = lr_s;
        end

        if (!ENABLE) begin
            state_d = SYNC_WAIT;
            cnt_d   = '0;
        end else if (sclk_rise) begin
            if (lr_s != lr_prev_q) begin
                // The bit at a boundary edge is the previous slot's trailing bit.
                cnt_d   = '0;
                shift_d = '0;
                case (state_q)
                    LEFT, RIGHT: begin
                        if (cnt_q != CNT_W'(SLOT_BITS - 1)) begin
                            frame_err_d = 1'b1;
                            state_d     = SYNC_WAIT;
                        end else begin
                            state_d = lr_s ? RIGHT : LEFT;
                        end
                    end
                    default: begin
                        if (!lr_s) begin
                            state_d = LEFT;
                        end
                    end
                endcase
            end else begin
                if (cnt_q != CNT_W'(SLOT_BITS)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (state_q != SYNC_WAIT && take_bit_c) begin
                    shift_d = shift_in_c;
                end
                if (state_q == LEFT && word_done_c) begin
                    left_d = shift_in_c;
                end
                if (state_q == RIGHT && word_done_c) begin
                    if (FIFO_FULL) begin
                        overrun_d = 1'b1;
                    end else begin
                        write_d = 1'b1;
                        audio_d = {left_q, shift_in_c};
                    end
                end
            end
        end

        if (CLEAR) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    assign FIFO_WRITE = write_q;
    assign AUDIO      = audio_q;
    assign OVERRUN    = overrun_q;
    assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives standard I2S frames and checks writes, flags and latency.
module tb_i2s_rx;
    import i2s_pkg::*;

    localparam int DB   = 24;
    localparam int HALF = 178;

    logic        CLK;
    logic        RESET_N;
    logic        ENABLE;
    logic        CLEAR;
    logic        SCLK;
    logic        LRCLK;
    logic        DOUT;
    logic        FIFO_FULL;
    logic        FIFO_WRITE;
    logic [47:0] AUDIO;
    logic        OVERRUN;
    logic        FRAME_ERR;

    int          n_cmp  = 0;
    int          n_err  = 0;
    int          wr_cnt = 0;
    logic [47:0] wr_q[$];

    i2s_rx #(.DATA_BITS(DB), .SLOT_BITS(32)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .ENABLE     (ENABLE),
        .CLEAR      (CLEAR),
        .SCLK       (SCLK),
        .LRCLK      (LRCLK),
        .DOUT       (DOUT),
        .FIFO_FULL  (FIFO_FULL),
        .FIFO_WRITE (FIFO_WRITE),
        .AUDIO      (AUDIO),
        .OVERRUN    (OVERRUN),
        .FRAME_ERR  (FRAME_ERR)
    );

    // Clock edges fall on odd times; all SCLK activity happens on even times.
    initial begin
        CLK = 1'b0;
        #5;
        forever #10 CLK = ~CLK;
    end

    always @(negedge CLK) begin
        if (FIFO_WRITE === 1'b1) begin
            wr_cnt++;
            wr_q.push_back(AUDIO);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] pair(input logic [23:0] l, input logic [23:0] r);
        sample_pair_t p;
        p.left  = l;
        p.right = r;
        return p;
    endfunction

    task automatic expect_write(input string tag, input logic [47:0] exp);
        check({tag, "_present"}, 64'(wr_q.size() > 0), 64'd1);
        if (wr_q.size() > 0) check(tag, 64'(wr_q.pop_front()), 64'(exp));
    endtask

    // mode 1: exact write latency; mode 2: CLEAR lands on the same edge as an overrun.
    task automatic probe(input int mode, input logic [47:0] exp);
        @(posedge CLK);
        @(posedge CLK); #1;
        check("lat_t1_idle", 64'(FIFO_WRITE), 64'd0);
        if (mode == 2) CLEAR = 1'b1;
        @(posedge CLK); #1;
        CLEAR = 1'b0;
        if (mode == 1) begin
            check("lat_t2_write", 64'(FIFO_WRITE), 64'd1);
            check("lat_t2_audio", 64'(AUDIO), 64'(exp));
        end else begin
            check("coll_overrun", 64'(OVERRUN), 64'd0);
            check("coll_no_write", 64'(FIFO_WRITE), 64'd0);
        end
        @(posedge CLK); #1;
        check("lat_t3_idle", 64'(FIFO_WRITE), 64'd0);
    endtask

    task automatic send_slot(input logic lr, input logic [23:0] data, input int nbits,
                             input int mode, input logic [47:0] exp);
        time t_rise;
        for (int k = 0; k < nbits; k++) begin
            LRCLK = lr;
            DOUT  = (k >= 1 && k <= DB) ? data[DB-k] : 1'b0;
            #HALF;
            SCLK   = 1'b1;
            t_rise = $time;
            if (mode != 0 && k == DB) probe(mode, exp);
            #(HALF - ($time - t_rise));
            SCLK = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                              input int ls, input int rs, input int mode);
        send_slot(1'b0, l, ls, 0, 48'd0);
        send_slot(1'b1, r, rs, mode, pair(l, r));
    endtask

    task automatic clear_pulse();
        @(negedge CLK);
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        #1;
    endtask

    task automatic set_enable(input logic v);
        @(negedge CLK);
        ENABLE = v;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_write"},     64'(FIFO_WRITE), 64'd0);
        check({tag, "_audio"},     64'(AUDIO),      64'd0);
        check({tag, "_overrun"},   64'(OVERRUN),    64'd0);
        check({tag, "_frame_err"}, 64'(FRAME_ERR),  64'd0);
    endtask

    initial begin
        RESET_N   = 1'b1;
        ENABLE    = 1'b1;
        CLEAR     = 1'b0;
        FIFO_FULL = 1'b0;
        SCLK      = 1'b0;
        LRCLK     = 1'b1;
        DOUT      = 1'b0;
        #10 RESET_N = 1'b0;
        #90;
        check_reset_outputs("rst");

        // Reset released mid right slot, then three full frames
        send_slot(1'b1, 24'h000000, 8, 0, 48'd0);
        RESET_N = 1'b1;
        send_slot(1'b1, 24'hABCDEF, 20, 0, 48'd0);
        check("align_partial_none", 64'(wr_cnt), 64'd0);
        send_frame(24'h800001, 24'h7FFFFE, 32, 32, 1);
        send_frame(24'h123456, 24'hABCDEF, 32, 32, 0);
        send_frame(24'hFFFFFF, 24'h000000, 32, 32, 0);
        check("align_writes", 64'(wr_cnt), 64'd3);
        expect_write("basic_audio",  48'h8000017FFFFE);
        expect_write("frame2_audio", 48'h123456ABCDEF);
        expect_write("frame3_audio", 48'hFFFFFF000000);
        check("basic_overrun",   64'(OVERRUN),   64'd0);
        check("basic_frame_err", 64'(FRAME_ERR), 64'd0);

        // Overrun: one frame dropped, next written, flag sticky until CLEAR
        FIFO_FULL = 1'b1;
        send_frame(24'h000001, 24'h000002, 32, 32, 0);
        FIFO_FULL = 1'b0;
        check("ovr_dropped", 64'(wr_cnt),  64'd3);
        check("ovr_set",     64'(OVERRUN), 64'd1);
        send_frame(24'h654321, 24'h13579B, 32, 32, 0);
        check("ovr_next_written", 64'(wr_cnt), 64'd4);
        expect_write("ovr_next_audio", 48'h65432113579B);
        check("ovr_sticky", 64'(OVERRUN), 64'd1);
        clear_pulse();
        check("ovr_cleared", 64'(OVERRUN), 64'd0);

        // Short left slot, then resync on the following frame
        send_frame(24'h111111, 24'h222222, 20, 32, 0);
        check("short_frame_err", 64'(FRAME_ERR), 64'd1);
        check("short_no_write",  64'(wr_cnt),    64'd4);
        send_frame(24'h333333, 24'h444444, 32, 32, 0);
        check("resync_written", 64'(wr_cnt), 64'd5);
        expect_write("resync_audio", 48'h333333444444);
        clear_pulse();
        check("ferr_cleared", 64'(FRAME_ERR), 64'd0);

        // ENABLE low for two frames, then capture resumes
        set_enable(1'b0);
        send_frame(24'hAAAAAA, 24'h555555, 32, 32, 0);
        send_frame(24'h010203, 24'h040506, 32, 32, 0);
        check("dis_no_write", 64'(wr_cnt), 64'd5);
        set_enable(1'b1);
        send_frame(24'h0F0F0F, 24'hF0F0F0, 32, 32, 0);
        check("en_resumed", 64'(wr_cnt), 64'd6);
        expect_write("en_audio", 48'h0F0F0FF0F0F0);
        check("en_no_frame_err", 64'(FRAME_ERR), 64'd0);

        // CLEAR on the same edge as an overrun event
        FIFO_FULL = 1'b1;
        send_frame(24'h000111, 24'h000222, 32, 32, 2);
        FIFO_FULL = 1'b0;
        check("coll_total_writes", 64'(wr_cnt),  64'd6);
        check("coll_overrun_held", 64'(OVERRUN), 64'd0);

        // Set both sticky flags, then reset mid-frame
        FIFO_FULL = 1'b1;
        send_frame(24'h777777, 24'h888888, 32, 32, 0);
        FIFO_FULL = 1'b0;
        check("pre_rst_overrun", 64'(OVERRUN), 64'd1);
        send_frame(24'h999999, 24'h000000, 20, 32, 0);
        check("pre_rst_frame_err", 64'(FRAME_ERR), 64'd1);
        send_slot(1'b0, 24'hC3C3C3, 10, 0, 48'd0);
        RESET_N = 1'b0;
        #2;
        check_reset_outputs("midrst");
        send_slot(1'b0, 24'h000000, 22, 0, 48'd0);
        send_slot(1'b1, 24'h000000, 10, 0, 48'd0);
        RESET_N = 1'b1;
        send_slot(1'b1, 24'h000000, 22, 0, 48'd0);
        check("post_rst_none", 64'(wr_cnt), 64'd6);
        send_frame(24'h5A5A5A, 24'hA5A5A5, 32, 32, 0);
        check("post_rst_written", 64'(wr_cnt), 64'd7);
        expect_write("post_rst_audio", 48'h5A5A5AA5A5A5);
        check("post_rst_overrun",   64'(OVERRUN),   64'd0);
        check("post_rst_frame_err", 64'(FRAME_ERR), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
